// File: rtl/alu_pkg.sv
// Shared execute-stage ALU definitions: operand widths, control codes and
// the per-requester operand bundle.
package alu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned SHAMT_W    = $clog2(XLEN);

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_RSVD = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLT  = 4'b1001,
    ALU_SLTU = 4'b1010
  } alu_op_e;

  typedef struct packed {
    logic [XLEN-1:0]       d1;
    logic [XLEN-1:0]       d2;
    logic [ALU_CTRL_W-1:0] ctrl;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters, the shared ALU port and
// the result consumer.
interface alu_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]                                     req_valid;
  logic [NREQ-1:0]                                     req_ready;
  logic [NREQ-1:0][alu_pkg::XLEN-1:0]                  req_d1;
  logic [NREQ-1:0][alu_pkg::XLEN-1:0]                  req_d2;
  logic [NREQ-1:0][alu_pkg::ALU_CTRL_W-1:0]            req_ctrl;
  logic                                                rsp_valid;
  logic                                                rsp_ready;
  logic [IDW-1:0]                                      rsp_id;
  logic [alu_pkg::XLEN-1:0]                            rsp_result;
  logic                                                rsp_zero;

  modport master (
    output req_valid, req_d1, req_d2, req_ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_d1, req_d2, req_ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

endinterface

// File: rtl/ALU.sv
// Combinational execute-stage ALU; unknown and reserved codes yield zero.
module ALU
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]       i_d1,
  input  logic [XLEN-1:0]       i_d2,
  input  logic [ALU_CTRL_W-1:0] i_ctrl,
  output logic [XLEN-1:0]       o_result,
  output logic                  o_zero
);

  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt = i_d2[SHAMT_W-1:0];

  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_d1 + i_d2;
      ALU_SUB:  o_result = i_d1 - i_d2;
      ALU_AND:  o_result = i_d1 & i_d2;
      ALU_OR:   o_result = i_d1 | i_d2;
      ALU_XOR:  o_result = i_d1 ^ i_d2;
      ALU_SLL:  o_result = i_d1 << w_shamt;
      ALU_SRL:  o_result = i_d1 >> w_shamt;
      ALU_SRA:  o_result = $unsigned($signed(i_d1) >>> w_shamt);
      ALU_SLT:  o_result = XLEN'($signed(i_d1) < $signed(i_d2));
      ALU_SLTU: o_result = XLEN'(i_d1 < i_d2);
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr, ptr moves past the
// winner only when the grant is actually consumed.
module rr_arbiter #(
  parameter int unsigned N   = 2,
  parameter int unsigned IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;
  int unsigned    w_idx;
  logic [IDW-1:0] w_idx_t;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    w_idx_t  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Wrap ptr+k into 0..N-1 without a divider; N need not be a power of 2.
      w_idx = 32'(r_ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      w_idx_t = IDW'(w_idx);
      if (!w_found && req[w_idx_t]) begin
        grant[w_idx_t] = 1'b1;
        grant_id       = w_idx_t;
        w_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && (|grant)) begin
      r_ptr <= (32'(grant_id) == N - 1) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ valid/ready requesters; the result is held in
// a single tagged response register (1-cycle latency, 1 op/cycle).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_grant_id;
  logic            w_adv;
  logic            w_xfer;
  alu_req_t        w_sel;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_zero;

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [XLEN-1:0] r_rsp_result;
  logic            r_rsp_zero;

  assign w_adv         = ~r_rsp_valid | bus.rsp_ready;
  // rst_n gating keeps req_ready low throughout reset even with valid inputs.
  assign bus.req_ready = w_grant & {NREQ{w_adv & rst_n}};
  assign w_xfer        = |bus.req_ready;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.req_valid),
    .advance  (w_adv),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_sel.d1   = w_sel.d1   | (bus.req_d1[i]   & {XLEN{w_grant[i]}});
      w_sel.d2   = w_sel.d2   | (bus.req_d2[i]   & {XLEN{w_grant[i]}});
      w_sel.ctrl = w_sel.ctrl | (bus.req_ctrl[i] & {ALU_CTRL_W{w_grant[i]}});
    end
  end

  ALU u_alu (
    .i_d1     (w_sel.d1),
    .i_d2     (w_sel.d2),
    .i_ctrl   (w_sel.ctrl),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant_id;
      r_rsp_result <= w_alu_result;
      r_rsp_zero   <= w_alu_zero;
    end else if (bus.rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_zero   = r_rsp_zero;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `ALU` instance of the execute stage between `NREQ` requesters, e.g. the integer pipe, the branch-compare unit and the address generator. Each requester uses a valid/ready request channel. A round-robin arbiter selects one requester per cycle and drives the ALU with that requester's operands. The result is captured in a one-entry response register tagged with the winner's index, so ALU latency is one cycle and throughput is one operation per cycle.

## Interface
- `NREQ`, default 2: number of requesters; legal range 2..4.
- `IDW`, default `$clog2(NREQ)`: width of the requester index.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset is asynchronous and active-low.
- `req_valid` in `NREQ`: per-requester request valid.
- `req_ready` out `NREQ`: per-requester request accepted this cycle.
- `req_d1` in `NREQ`x32: packed array, operand 1 for each requester.
- `req_d2` in `NREQ`x32: packed array, operand 2 for each requester.
- `req_ctrl` in `NREQ`x4: packed array, ALU control code for each requester; passed through opaquely.
- `rsp_valid` out 1: response register holds a result.
- `rsp_ready` in 1: consumer takes the response this cycle.
- `rsp_id` out `IDW`: index of the requester that produced the response.
- `rsp_result` out 32: registered ALU `result`.
- `rsp_zero` out 1: registered ALU `zero`.

## Operation
- **Arbitration.** Round-robin over the requesters with `req_valid` high.
  - Search starts at pointer `ptr` and wraps modulo `NREQ`.
  - The grant is recomputed combinationally every cycle.
  - With no valid requester there is no grant and the ALU inputs are don't-care.
- **Datapath.** The ALU is driven by the granted requester's `d1`/`d2`/`ctrl` through a one-hot mux.
- **Stall condition.** `adv = ~rsp_valid | rsp_ready`.
- **Request ready.** `req_ready[i] = grant[i] & adv`. At most one bit is set per cycle.
- **Transfer.** A transfer occurs when `req_valid[i] & req_ready[i]`. On a transfer:
  - `rsp_result`/`rsp_zero` load from the ALU.
  - `rsp_id` loads `i`.
  - `rsp_valid` is set to 1.
  - `ptr` loads `(i+1) mod NREQ`.
- **Drain.** `rsp_ready` with no new transfer clears `rsp_valid`. The data registers hold their values.
- **Simultaneous drain and accept.** The new result loads and `rsp_valid` stays 1. No bubble is inserted.
- **Full stall.** While `rsp_valid & ~rsp_ready`, all `req_ready` are 0 and both `ptr` and the response registers hold.
- **Requester rules.** A requester holds `req_valid` and its operands stable until `req_ready`. Deasserting `req_valid` before acceptance is permitted; nothing is recorded.
- **Fairness.** A continuously valid requester is accepted within `NREQ` transfers.
- **`ptr` range.** `ptr` never reaches `NREQ`. An out-of-range value is impossible by construction; the bench asserts this.

## Timing
- **Reset values.** `rst_n` low asynchronously forces:
  - `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_zero=0`.
  - `ptr=0`, so requester 0 has highest priority first.
  - `req_ready` is 0 while `rst_n` is low.
- **Reset mid-operation.** A pending response is discarded. Requesters must re-present their requests.
- **Latency.** Request accepted at edge N, so `rsp_valid`/`rsp_result` are valid after edge N.
- **Throughput.** Sustained one transfer per cycle while `rsp_ready` is held at 1.
- **Combinational paths.**
  - `req_ready` depends combinationally on `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`.
  - The ALU sits between the request mux and the response register, which sets the critical path.
  - No combinational path from `req_*` to `rsp_*`.

## Structure
- **Shared package `alu_pkg`.**
  - `XLEN=32`.
  - `ALU_CTRL_W=4`.
  - Named control codes, including `ALU_ADD=4'b0000` and `ALU_SUB=4'b0001`. Code `4'b0100` is reserved/default.
  - `typedef struct packed {logic [XLEN-1:0] d1, d2; logic [ALU_CTRL_W-1:0] ctrl;} alu_req_t`.
- **Sub-module `rr_arbiter`.**
  - Parameter `N`.
  - Inputs: `clk`, `rst_n`, `req[N]`, `advance`.
  - Outputs: one-hot `grant[N]` and `grant_id`.
  - Owns `ptr`, which updates only when `advance` is high and the grant is non-zero.
- **Top level.** `alu_arbiter` instantiates `rr_arbiter`, the request mux, the existing `ALU` and the response register.

## Test plan
- **Reset.**
  - Stimulus: assert `rst_n=0` mid-stream.
  - Response: all `rsp_*` are 0 immediately, without a clock edge; `req_ready=0`; after release, requester 0 wins the first contest.
- **Single requester, ADD.**
  - Stimulus: req0 with `d1=0x10101010`, `d2=0x01010101`, `ctrl=ALU_ADD`, `rsp_ready=1`.
  - Response: one cycle later `rsp_valid=1`, `rsp_id=0`, `rsp_result=0x11111111`, `rsp_zero=0`.
- **SUB, zero flag.**
  - Stimulus: req1 with `d1=d2=0x10101010`, `ctrl=ALU_SUB`.
  - Response: `rsp_result=0`, `rsp_zero=1`, `rsp_id=1`.
- **Fairness.**
  - Stimulus: both requesters valid for 6 cycles with `rsp_ready=1`.
  - Response: `rsp_id` sequence is 0,1,0,1,0,1; six results; no idle cycles.
- **Backpressure.**
  - Stimulus: hold `rsp_ready=0` for 3 cycles with a response pending.
  - Response: `req_ready=0`, and `rsp_*`/`ptr` are stable. When `rsp_ready` rises with req1 valid, the next result loads in the same cycle with no bubble.
- **Randomized scoreboard.**
  - Stimulus: `NREQ=4`, random valid and ready patterns.
  - Response: every accepted request appears exactly once with the correct `rsp_id`, matching a reference `ALU` instance fed the same operands.
